serial_adder: RTL and testbench

- Parametrised multi-cycle adder, successor to the combinational half adder.
- Adds two WIDTH-bit operands plus carry-in, DIGIT bits per clock, using a registered carry between digits.
- Start/busy/done handshake; sits beside datapath blocks where area matters more than latency.
- With WIDTH=1, DIGIT=1, cin=0 the result equals a half adder: sum=a^b, cout=a&b.

---
 rtl/serial_adder.sv | 141 ++++++++++++++
 tb/tb_serial_adder.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder: adds WIDTH-bit a + b + cin, DIGIT bits per clock, with a start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $fatal(1, "serial_adder: WIDTH must be >= 1 and a multiple of DIGIT");
        end
    endgenerate

    localparam int N     = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    logic [DIGIT:0]         digit_sum;
    logic [WIDTH+DIGIT-1:0] res_shift;
    logic                   last_digit;
    logic                   accept;

    // One digit of the ripple: {carry_out, digit} from the low DIGIT bits plus the stored carry.
    assign digit_sum  = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    assign res_shift  = {digit_sum[DIGIT-1:0], res_q};
    assign last_digit = (cnt_q == CNT_W'(N - 1));
    assign accept     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_RUN: begin
                res_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = digit_sum[DIGIT];
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_digit) begin
                    state_d = ST_DONE;
                    sum_d   = res_shift[WIDTH+DIGIT-1:DIGIT];
                    cout_d  = digit_sum[DIGIT];
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d = ST_RUN;
            a_d     = a;
            b_d     = b;
            carry_d = cin;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    logic msb_cin;

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ cin_msb = sum_msb.
    assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];

    always_comb begin
        ovf_d = ovf_q;
        if (state_q == ST_RUN && last_digit) begin
            ovf_d = msb_cin ^ digit_sum[DIGIT];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: three instances (1/1, 8/1, 8/4) driven from one linear sequence.
// Covers the SERIAL_ADDER_OVF_EN port when that macro is defined.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // half-adder instance
  logic       h_start = 1'b0, h_a = 1'b0, h_b = 1'b0, h_cin = 1'b0;
  logic       h_busy, h_done, h_sum, h_cout;
  // 8-bit, 1 bit per cycle
  logic       e_start = 1'b0, e_cin = 1'b0;
  logic [7:0] e_a = '0, e_b = '0, e_sum;
  logic       e_busy, e_done, e_cout;
  // 8-bit, 4 bits per cycle
  logic       q_start = 1'b0, q_cin = 1'b0;
  logic [7:0] q_a = '0, q_b = '0, q_sum;
  logic       q_busy, q_done, q_cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       h_ovf, e_ovf, q_ovf;
`endif

  serial_adder #(.WIDTH(1), .DIGIT(1)) u_h (
    .clk(clk), .rst(rst), .start(h_start), .a(h_a), .b(h_b), .cin(h_cin),
    .busy(h_busy), .done(h_done), .sum(h_sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(h_ovf),
`endif
    .cout(h_cout));

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_e (
    .clk(clk), .rst(rst), .start(e_start), .a(e_a), .b(e_b), .cin(e_cin),
    .busy(e_busy), .done(e_done), .sum(e_sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(e_ovf),
`endif
    .cout(e_cout));

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_q (
    .clk(clk), .rst(rst), .start(q_start), .a(q_a), .b(q_b), .cin(q_cin),
    .busy(q_busy), .done(q_done), .sum(q_sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(q_ovf),
`endif
    .cout(q_cout));

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic get_done(input int sel);
    return (sel == 0) ? h_done : (sel == 1) ? e_done : q_done;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? h_busy : (sel == 1) ? e_busy : q_busy;
  endfunction

  // Step until done rises (bounded), counting cycles spent with busy high.
  task automatic wait_done(input int sel, input string tag, output int busy_n);
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (get_done(sel)) break;
      if (get_busy(sel)) busy_n++;
      tick();
    end
    check({tag, "_done_seen"}, 32'(get_done(sel)), 32'd1);
    check({tag, "_busy_at_done"}, 32'(get_busy(sel)), 32'd0);
  endtask

  int bn;
  int c1;
  int n_done;
  logic [1:0] ha_vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

  initial begin
    // reset
    tick(); tick();
    rst = 1'b0;
    check("rst_e_sum", 32'(e_sum), 32'h0);
    check("rst_e_flags", {29'd0, e_busy, e_done, e_cout}, 32'h0);
    check("rst_q_flags", {21'd0, q_sum, q_busy, q_done, q_cout}, 32'h0);
    check("rst_h_flags", {28'd0, h_sum, h_busy, h_done, h_cout}, 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", {29'd0, h_ovf, e_ovf, q_ovf}, 32'h0);
`endif

    // half-adder equivalence: done one cycle after the start edge
    for (int i = 0; i < 4; i++) begin
      h_a = ha_vec[i][1];
      h_b = ha_vec[i][0];
      h_start = 1'b1;
      tick();
      h_start = 1'b0;
      check("ha_busy", 32'(h_busy), 32'd1);
      tick();
      check("ha_done", 32'(h_done), 32'd1);
      check("ha_sum", 32'(h_sum), 32'(ha_vec[i][1] ^ ha_vec[i][0]));
      check("ha_cout", 32'(h_cout), 32'(ha_vec[i][1] & ha_vec[i][0]));
      tick();
      check("ha_done_drop", 32'(h_done), 32'd0);
    end

    // 0xFF + 0x01: wraps to 0x00 with carry out, 8 busy cycles
    e_a = 8'hFF; e_b = 8'h01; e_cin = 1'b0; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    wait_done(1, "e_ff01", bn);
    check("e_ff01_busy_cycles", 32'(bn), 32'd8);
    check("e_ff01_sum", 32'(e_sum), 32'h00);
    check("e_ff01_cout", 32'(e_cout), 32'd1);
    tick();
    check("e_ff01_single_pulse", 32'(e_done), 32'd0);
    check("e_ff01_sum_hold", 32'(e_sum), 32'h00);

    // start mid-RUN with different operands is ignored
    e_a = 8'h0A; e_b = 8'h05; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    tick(); tick();
    e_a = 8'h10; e_b = 8'h10; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    wait_done(1, "e_ignore", bn);
    check("e_ignore_sum", 32'(e_sum), 32'h0F);
    check("e_ignore_cout", 32'(e_cout), 32'd0);
    tick();

    // reset during RUN cycle 3 aborts with no done
    e_a = 8'h55; e_b = 8'h11; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("e_abort_sum", 32'(e_sum), 32'h0);
    check("e_abort_flags", {29'd0, e_busy, e_done, e_cout}, 32'h0);
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (e_done) n_done++;
    end
    check("e_abort_no_done", 32'(n_done), 32'd0);
    e_a = 8'h12; e_b = 8'h34; e_start = 1'b1;
    tick();
    e_start = 1'b0;
    wait_done(1, "e_after_rst", bn);
    check("e_after_rst_sum", 32'(e_sum), 32'h46);
    check("e_after_rst_cout", 32'(e_cout), 32'd0);
    tick();

    // back-to-back: start held through DONE
    e_a = 8'hAA; e_b = 8'h55; e_cin = 1'b0; e_start = 1'b1;
    tick();
    e_a = 8'h01; e_b = 8'h01;
    wait_done(1, "e_b2b1", bn);
    c1 = cyc;
    check("e_b2b1_sum", 32'(e_sum), 32'hFF);
    check("e_b2b1_cout", 32'(e_cout), 32'd0);
    tick();
    e_start = 1'b0;
    check("e_b2b_rerun_busy", 32'(e_busy), 32'd1);
    check("e_b2b_sum_hold", 32'(e_sum), 32'hFF);
    wait_done(1, "e_b2b2", bn);
    check("e_b2b_spacing", 32'(cyc - c1), 32'd9);
    check("e_b2b2_sum", 32'(e_sum), 32'h02);
    check("e_b2b2_cout", 32'(e_cout), 32'd0);
    tick();

    // DIGIT=4: 0x7F + 0x00 + 1 -> 0x80, two RUN cycles
    q_a = 8'h7F; q_b = 8'h00; q_cin = 1'b1; q_start = 1'b1;
    tick();
    q_start = 1'b0;
    wait_done(2, "q_7f", bn);
    check("q_7f_busy_cycles", 32'(bn), 32'd2);
    check("q_7f_sum", 32'(q_sum), 32'h80);
    check("q_7f_cout", 32'(q_cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("q_7f_ovf", 32'(q_ovf), 32'd1);
`endif
    tick();

    q_a = 8'h05; q_b = 8'h03; q_cin = 1'b0; q_start = 1'b1;
    tick();
    q_start = 1'b0;
    wait_done(2, "q_0503", bn);
    check("q_0503_sum", 32'(q_sum), 32'h08);
    check("q_0503_cout", 32'(q_cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("q_0503_ovf", 32'(q_ovf), 32'd0);
`endif
    tick();

    // all ones plus carry-in
    q_a = 8'hFF; q_b = 8'hFF; q_cin = 1'b1; q_start = 1'b1;
    tick();
    q_start = 1'b0;
    wait_done(2, "q_ones", bn);
    check("q_ones_sum", 32'(q_sum), 32'hFF);
    check("q_ones_cout", 32'(q_cout), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("q_ones_ovf", 32'(q_ovf), 32'd0);
`endif
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
